// File: rtl/tlbctl_pkg.sv
// Shared types and constants for the DTLB miss controller and its entry array.
package tlbctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FILL  = 2'd2,
        FAULT = 2'd3
    } tlb_state_e;

    localparam int PTE_V_BIT     = 15;
    localparam int PTE_W_BIT     = 14;
    localparam int PAGE_OFFSET_W = 12;
    localparam int VPN_W         = 4;

    localparam logic [1:0] CAUSE_INVALID = 2'b01;
    localparam logic [1:0] CAUSE_WPROT   = 2'b10;

    // Single-level table of 16-bit PTEs indexed by VPN; wraps modulo 2^16.
    function automatic logic [15:0] pte_addr(input logic [15:0] base,
                                             input logic [VPN_W-1:0] vpn);
        return base + {11'b0, vpn, 1'b0};
    endfunction

endpackage

// File: rtl/tlb_miss_controller_tlb_array.sv
// Fully-associative DTLB storage: parallel lookup, victim choice with
// round-robin fallback, single write port and whole-array flush.
module tlb_array
    import tlbctl_pkg::*;
#(
    parameter int TLB_ENTRIES = 4,
    parameter int PPN_W       = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             hit,
    output logic             hit_w,
    output logic [PPN_W-1:0] hit_ppn,
    input  logic             wr_en,
    input  logic [VPN_W-1:0] wr_vpn,
    input  logic             wr_w,
    input  logic [PPN_W-1:0] wr_ppn,
    input  logic             flush
);

    localparam int IDX_W = $clog2(TLB_ENTRIES);

    logic [TLB_ENTRIES-1:0] valid_q, valid_d;
    logic [TLB_ENTRIES-1:0] w_q, w_d;
    logic [VPN_W-1:0]       vpn_q [TLB_ENTRIES];
    logic [VPN_W-1:0]       vpn_d [TLB_ENTRIES];
    logic [PPN_W-1:0]       ppn_q [TLB_ENTRIES];
    logic [PPN_W-1:0]       ppn_d [TLB_ENTRIES];
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       hit_idx;
    logic [IDX_W-1:0]       victim;
    logic                   any_free;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (vpn_q[i] == lookup_vpn)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_w   = w_q[hit_idx];
    assign hit_ppn = ppn_q[hit_idx];

    always_comb begin
        any_free = 1'b0;
        victim   = rr_q;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                any_free = 1'b1;
                victim   = IDX_W'(i);
            end
        end
    end

    // Flush clears before the write lands, so an entry filled on the same
    // edge survives; the victim is still chosen from pre-flush contents.
    always_comb begin
        valid_d = valid_q;
        w_d     = w_q;
        vpn_d   = vpn_q;
        ppn_d   = ppn_q;
        rr_d    = rr_q;
        if (wr_en) begin
            w_d[victim]   = wr_w;
            vpn_d[victim] = wr_vpn;
            ppn_d[victim] = wr_ppn;
            if (!any_free) begin
                rr_d = rr_q + IDX_W'(1);
            end
        end
        if (flush) begin
            valid_d = '0;
            rr_d    = '0;
        end
        if (wr_en) begin
            valid_d[victim] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            w_q     <= '0;
            rr_q    <= '0;
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                vpn_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            w_q     <= w_d;
            rr_q    <= rr_d;
            vpn_q   <= vpn_d;
            ppn_q   <= ppn_d;
        end
    end

endmodule

// File: rtl/tlb_miss_controller.sv
// Data-side TLB lookup sequencer: hit translation, page-table walk on miss,
// fill and replay, fault reporting. Optional flush port via TLBCTL_FLUSH_EN.
//
// state | meaning
// IDLE  | translate in the request cycle; detect miss or write-protect
// WALK  | PTE read outstanding on the req/ack port
// FILL  | write walked PTE into the DTLB; replay hits next cycle
// FAULT | one-cycle exception pulse; stage drains the faulting op
module tlb_miss_controller
    import tlbctl_pkg::*;
#(
    parameter int TLB_ENTRIES = 4,
    parameter int PPN_W       = 8
)
(
    input  logic                   clk,
    input  logic                   reset,
`ifdef TLBCTL_FLUSH_EN
    input  logic                   tlb_flush,
`endif
    input  logic                   req_valid,
    input  logic                   req_is_store,
    input  logic [15:0]            req_vaddr,
    input  logic [2:0]             req_rob,
    input  logic [15:0]            ptbr,
    output logic                   enable_tlblookup,
    output logic                   xlat_valid,
    output logic [PPN_W+11:0]      xlat_paddr,
    output logic                   mem_req,
    output logic [15:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [15:0]            mem_rdata,
    output logic                   exc_valid,
    output logic [2:0]             exc_rob,
    output logic [1:0]             exc_cause
);

    tlb_state_e       state_q, state_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic             store_q, store_d;
    logic [2:0]       rob_q, rob_d;
    logic             pte_w_q, pte_w_d;
    logic [PPN_W-1:0] pte_ppn_q, pte_ppn_d;
    logic             mem_req_q, mem_req_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic             exc_valid_q, exc_valid_d;
    logic [2:0]       exc_rob_q, exc_rob_d;
    logic [1:0]       exc_cause_q, exc_cause_d;

    logic [VPN_W-1:0] req_vpn;
    logic             tlb_hit, tlb_hit_w, tlb_wr_en, tlb_flush_int, wprot_hit;
    logic [PPN_W-1:0] tlb_hit_ppn;
    logic             unused_pte_bits;

    assign req_vpn         = req_vaddr[15:PAGE_OFFSET_W];
    assign wprot_hit       = req_is_store && !tlb_hit_w;
    assign unused_pte_bits = ^(mem_rdata[13:0] >> PPN_W);

    tlb_array #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .PPN_W       (PPN_W)
    ) u_tlb (
        .clk        (clk),
        .reset      (reset),
        .lookup_vpn (req_vpn),
        .hit        (tlb_hit),
        .hit_w      (tlb_hit_w),
        .hit_ppn    (tlb_hit_ppn),
        .wr_en      (tlb_wr_en),
        .wr_vpn     (vpn_q),
        .wr_w       (pte_w_q),
        .wr_ppn     (pte_ppn_q),
        .flush      (tlb_flush_int)
    );

    always_comb begin
        state_d     = state_q;
        vpn_d       = vpn_q;
        store_d     = store_q;
        rob_d       = rob_q;
        pte_w_d     = pte_w_q;
        pte_ppn_d   = pte_ppn_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        exc_valid_d = 1'b0;
        exc_rob_d   = exc_rob_q;
        exc_cause_d = exc_cause_q;
        tlb_wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (tlb_hit) begin
                        if (wprot_hit) begin
                            state_d     = FAULT;
                            exc_valid_d = 1'b1;
                            exc_rob_d   = req_rob;
                            exc_cause_d = CAUSE_WPROT;
                        end
                    end else begin
                        vpn_d      = req_vpn;
                        store_d    = req_is_store;
                        rob_d      = req_rob;
                        mem_addr_d = pte_addr(ptbr, req_vpn);
                        mem_req_d  = 1'b1;
                        state_d    = WALK;
                    end
                end
            end
            WALK: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    pte_w_d   = mem_rdata[PTE_W_BIT];
                    pte_ppn_d = mem_rdata[PPN_W-1:0];
                    if (!mem_rdata[PTE_V_BIT]) begin
                        state_d     = FAULT;
                        exc_valid_d = 1'b1;
                        exc_rob_d   = rob_q;
                        exc_cause_d = CAUSE_INVALID;
                    end else if (store_q && !mem_rdata[PTE_W_BIT]) begin
                        state_d     = FAULT;
                        exc_valid_d = 1'b1;
                        exc_rob_d   = rob_q;
                        exc_cause_d = CAUSE_WPROT;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                tlb_wr_en = 1'b1;
                state_d   = IDLE;
            end
            FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            vpn_q       <= '0;
            store_q     <= 1'b0;
            rob_q       <= '0;
            pte_w_q     <= 1'b0;
            pte_ppn_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            exc_valid_q <= 1'b0;
            exc_rob_q   <= '0;
            exc_cause_q <= '0;
        end else begin
            state_q     <= state_d;
            vpn_q       <= vpn_d;
            store_q     <= store_d;
            rob_q       <= rob_d;
            pte_w_q     <= pte_w_d;
            pte_ppn_q   <= pte_ppn_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            exc_valid_q <= exc_valid_d;
            exc_rob_q   <= exc_rob_d;
            exc_cause_q <= exc_cause_d;
        end
    end

`ifdef TLBCTL_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    // Flushes seen mid-miss are deferred to the FILL/FAULT exit edge.
    always_comb begin
        flush_pend_d  = flush_pend_q;
        tlb_flush_int = 1'b0;
        case (state_q)
            IDLE: begin
                tlb_flush_int = tlb_flush;
                flush_pend_d  = 1'b0;
            end
            WALK: begin
                flush_pend_d = flush_pend_q || tlb_flush;
            end
            default: begin
                tlb_flush_int = flush_pend_q || tlb_flush;
                flush_pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    assign tlb_flush_int = 1'b0;
`endif

    always_comb begin
        xlat_valid = (state_q == IDLE) && req_valid && tlb_hit && !wprot_hit;
        xlat_paddr = xlat_valid ? {tlb_hit_ppn, req_vaddr[PAGE_OFFSET_W-1:0]} : '0;
        enable_tlblookup = 1'b1;
        case (state_q)
            IDLE:       enable_tlblookup = !req_valid || (tlb_hit && !wprot_hit);
            WALK, FILL: enable_tlblookup = 1'b0;
            default:    enable_tlblookup = 1'b1;
        endcase
        // Reset must release the stage even if a missing request is held.
        if (!reset) begin
            enable_tlblookup = 1'b1;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign exc_valid = exc_valid_q;
    assign exc_rob   = exc_rob_q;
    assign exc_cause = exc_cause_q;

endmodule

// File: tb/tb_tlb_miss_controller.sv
// Directed bench for tlb_miss_controller with a transaction-level DTLB model
// predicting every cycle's outputs; optional flush scenarios under TLBCTL_FLUSH_EN.
module tb_tlb_miss_controller;

    localparam int N     = 4;
    localparam int PPN_W = 8;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_is_store;
    logic [15:0] req_vaddr;
    logic [2:0]  req_rob;
    logic [15:0] ptbr;
    logic        enable_tlblookup;
    logic        xlat_valid;
    logic [19:0] xlat_paddr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        exc_valid;
    logic [2:0]  exc_rob;
    logic [1:0]  exc_cause;
`ifdef TLBCTL_FLUSH_EN
    logic        tlb_flush;
`endif

    tlb_miss_controller #(.TLB_ENTRIES(N), .PPN_W(PPN_W)) dut (
        .clk              (clk),
        .reset            (reset),
`ifdef TLBCTL_FLUSH_EN
        .tlb_flush        (tlb_flush),
`endif
        .req_valid        (req_valid),
        .req_is_store     (req_is_store),
        .req_vaddr        (req_vaddr),
        .req_rob          (req_rob),
        .ptbr             (ptbr),
        .enable_tlblookup (enable_tlblookup),
        .xlat_valid       (xlat_valid),
        .xlat_paddr       (xlat_paddr),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .exc_valid        (exc_valid),
        .exc_rob          (exc_rob),
        .exc_cause        (exc_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bit          exp_en, exp_xv, exp_mr, exp_ev;
    logic [19:0] exp_pa;
    logic [15:0] exp_ma;
    logic [2:0]  exp_rob;
    logic [1:0]  exp_cause;

    int          en_low_cnt = 0;
    int          mr_cnt = 0;
    logic [15:0] last_ma;
    logic [19:0] last_pa;
    logic [2:0]  last_rob;
    logic [1:0]  last_cause;

    bit          m_valid [N];
    logic [3:0]  m_vpn [N];
    bit          m_w [N];
    logic [7:0]  m_ppn [N];
    int          m_rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic compare_cycle();
        check("enable_tlblookup", 32'(enable_tlblookup), 32'(exp_en));
        check("xlat_valid", 32'(xlat_valid), 32'(exp_xv));
        if (exp_xv) check("xlat_paddr", 32'(xlat_paddr), 32'(exp_pa));
        check("mem_req", 32'(mem_req), 32'(exp_mr));
        if (exp_mr) check("mem_addr", 32'(mem_addr), 32'(exp_ma));
        check("exc_valid", 32'(exc_valid), 32'(exp_ev));
        if (exp_ev) begin
            check("exc_rob", 32'(exc_rob), 32'(exp_rob));
            check("exc_cause", 32'(exc_cause), 32'(exp_cause));
        end
        if (!enable_tlblookup) en_low_cnt++;
        if (mem_req) begin
            mr_cnt++;
            last_ma = mem_addr;
        end
        if (xlat_valid) last_pa = xlat_paddr;
        if (exc_valid) begin
            last_rob   = exc_rob;
            last_cause = exc_cause;
        end
    endtask

    function automatic int mdl_find(input logic [3:0] vpn);
        for (int i = 0; i < N; i++) if (m_valid[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    task automatic mdl_flush();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_rr = 0;
    endtask

    task automatic mdl_fill(input logic [3:0] vpn, input bit w, input logic [7:0] ppn, input bit pend);
        int v;
        v = -1;
        for (int i = 0; i < N; i++) if (!m_valid[i] && v < 0) v = i;
        if (v < 0) begin
            v = m_rr;
            m_rr = (m_rr + 1) % N;
        end
        if (pend) mdl_flush();
        m_valid[v] = 1'b1;
        m_vpn[v]   = vpn;
        m_w[v]     = w;
        m_ppn[v]   = ppn;
    endtask

    task automatic set_idle_exp();
        exp_en = 1'b1; exp_xv = 1'b0; exp_pa = '0; exp_mr = 1'b0; exp_ma = '0;
        exp_ev = 1'b0; exp_rob = '0; exp_cause = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flush(input bit f);
`ifdef TLBCTL_FLUSH_EN
        tlb_flush = f;
`else
        if (f) $display("note: flush requested without flush support");
`endif
    endtask

    // One load/store from first presentation to completion (hit, fault or replay).
    task automatic access(input bit st, input logic [15:0] va, input logic [2:0] rob,
                          input logic [15:0] pte, input int ack_n, input bit fl_now, input bit fl_walk);
        int idx;
        logic [3:0] vpn;
        logic [15:0] wa;
        vpn = va[15:12];
        idx = mdl_find(vpn);
        req_valid = 1'b1; req_is_store = st; req_vaddr = va; req_rob = rob;
        set_idle_exp();
        set_flush(fl_now);
        if (idx >= 0) begin
            if (st && !m_w[idx]) begin
                exp_en = 1'b0;
                tick();
                set_flush(1'b0);
                if (fl_now) mdl_flush();
                set_idle_exp();
                exp_ev = 1'b1; exp_rob = rob; exp_cause = 2'b10;
                tick();
            end else begin
                exp_xv = 1'b1;
                exp_pa = {m_ppn[idx], va[11:0]};
                tick();
                set_flush(1'b0);
                if (fl_now) mdl_flush();
            end
        end else begin
            exp_en = 1'b0;
            tick();
            set_flush(1'b0);
            if (fl_now) mdl_flush();
            wa = ptbr + {11'b0, vpn, 1'b0};
            for (int k = 1; k <= ack_n; k++) begin
                set_idle_exp();
                exp_en = 1'b0; exp_mr = 1'b1; exp_ma = wa;
                mem_ack   = (k == ack_n);
                mem_rdata = (k == ack_n) ? pte : 16'($urandom);
                set_flush(fl_walk && k == 1);
                tick();
            end
            mem_ack = 1'b0;
            set_flush(1'b0);
            if (!pte[15] || (st && !pte[14])) begin
                set_idle_exp();
                exp_ev = 1'b1; exp_rob = rob;
                exp_cause = !pte[15] ? 2'b01 : 2'b10;
                tick();
                if (fl_walk) mdl_flush();
            end else begin
                set_idle_exp();
                exp_en = 1'b0;
                tick();
                mdl_fill(vpn, pte[14], pte[7:0], fl_walk);
                set_idle_exp();
                exp_xv = 1'b1;
                exp_pa = {pte[7:0], va[11:0]};
                tick();
            end
        end
        req_valid = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int e0, m0;
        reset = 1'b0;
        req_valid = 1'b1; req_is_store = 1'b0; req_vaddr = 16'h3ABC; req_rob = 3'd0;
        ptbr = 16'h1000; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        set_flush(1'b0);
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        set_idle_exp();
        #3;
        check("rst_enable", 32'(enable_tlblookup), 32'd1);
        check("rst_xlat_valid", 32'(xlat_valid), 32'd0);
        check("rst_xlat_paddr", 32'(xlat_paddr), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_exc_valid", 32'(exc_valid), 32'd0);
        check("rst_exc_rob", 32'(exc_rob), 32'd0);
        check("rst_exc_cause", 32'(exc_cause), 32'd0);
        req_valid = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (chk_en) compare_cycle();
            end
        join_none

        tick();
        chk_en = 1'b1;
        tick();

        // Cold miss with 3-cycle walk
        e0 = en_low_cnt;
        access(1'b0, 16'h3ABC, 3'd1, 16'hC025, 3, 1'b0, 1'b0);
        check("cold_mem_addr", 32'(last_ma), 32'h1006);
        check("cold_paddr", 32'(last_pa), 32'h25ABC);
        check("cold_stall_cycles", 32'(en_low_cnt - e0), 32'd5);

        // Hit after fill
        e0 = en_low_cnt; m0 = mr_cnt;
        access(1'b0, 16'h3000, 3'd2, 16'h0000, 1, 1'b0, 1'b0);
        check("hit_paddr", 32'(last_pa), 32'h25000);
        check("hit_no_mem_req", 32'(mr_cnt - m0), 32'd0);
        check("hit_no_stall", 32'(en_low_cnt - e0), 32'd0);

        // Stray ack outside WALK
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        tick();

        // Invalid PTE on a store, 1-cycle walk; V=0 outranks W=0
        access(1'b1, 16'h7123, 3'd5, 16'h0012, 1, 1'b0, 1'b0);
        check("inv_exc_rob", 32'(last_rob), 32'd5);
        check("inv_exc_cause", 32'(last_cause), 32'd1);
        m0 = mr_cnt;
        access(1'b0, 16'h7123, 3'd0, 16'h8044, 2, 1'b0, 1'b0);
        check("inv_not_filled", 32'(mr_cnt != m0), 32'd1);

        // Write-protect on hit
        m0 = mr_cnt;
        access(1'b1, 16'h7FFF, 3'd2, 16'h0000, 1, 1'b0, 1'b0);
        check("wprot_hit_cause", 32'(last_cause), 32'd2);
        check("wprot_hit_rob", 32'(last_rob), 32'd2);
        check("wprot_hit_no_walk", 32'(mr_cnt - m0), 32'd0);

        // Write-protect found by the walk, then a store that fills
        access(1'b1, 16'hA000, 3'd6, 16'h8011, 2, 1'b0, 1'b0);
        check("wprot_walk_cause", 32'(last_cause), 32'd2);
        access(1'b1, 16'hB100, 3'd3, 16'hC0FF, 1, 1'b0, 1'b0);
        check("store_fill_paddr", 32'(last_pa), 32'hFF100);

        // PTE address wraps modulo 2^16
        ptbr = 16'hFFF0;
        access(1'b0, 16'hF123, 3'd0, 16'h80AB, 1, 1'b0, 1'b0);
        check("wrap_mem_addr", 32'(last_ma), 32'h000E);
        ptbr = 16'h1000;

        // Reset during WALK
        req_valid = 1'b1; req_is_store = 1'b0; req_vaddr = 16'h9456; req_rob = 3'd4;
        set_idle_exp(); exp_en = 1'b0;
        tick();
        set_idle_exp(); exp_en = 1'b0; exp_mr = 1'b1; exp_ma = 16'h1012;
        tick();
        chk_en = 1'b0;
        reset = 1'b0;
        #1;
        check("rstwalk_mem_req", 32'(mem_req), 32'd0);
        check("rstwalk_mem_addr", 32'(mem_addr), 32'd0);
        check("rstwalk_enable", 32'(enable_tlblookup), 32'd1);
        check("rstwalk_exc_rob", 32'(exc_rob), 32'd0);
        check("rstwalk_exc_cause", 32'(exc_cause), 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rstwalk_hold_mem_req", 32'(mem_req), 32'd0);
        reset = 1'b1;
        mdl_flush();
        set_idle_exp();
        chk_en = 1'b1;
        tick();
        m0 = mr_cnt;
        access(1'b0, 16'h3000, 3'd0, 16'hC025, 1, 1'b0, 1'b0);
        check("rstwalk_entries_cleared", 32'(mr_cnt != m0), 32'd1);

        // Replacement: fill VPN 0..4 into an empty 4-entry TLB
        mdl_flush();
        reset = 1'b0; #1; reset = 1'b1;
        tick();
        for (int v = 0; v <= 4; v++) begin
            access(1'b0, 16'((v << 12) | 16'h010), 3'(v), 16'(16'hC050 + v), 1 + (v % 2), 1'b0, 1'b0);
        end
        m0 = mr_cnt;
        for (int v = 1; v <= 4; v++) begin
            access(1'b0, 16'((v << 12) | 16'h234), 3'd1, 16'h0000, 1, 1'b0, 1'b0);
        end
        check("repl_survivors_hit", 32'(mr_cnt - m0), 32'd0);
        m0 = mr_cnt;
        access(1'b0, 16'h0444, 3'd2, 16'hC0A0, 1, 1'b0, 1'b0);
        check("repl_vpn0_evicted", 32'(mr_cnt != m0), 32'd1);
        for (int v = 5; v <= 8; v++) begin
            access(1'b0, 16'(v << 12), 3'd3, 16'(16'hC060 + v), 2, 1'b0, 1'b0);
        end
        for (int v = 0; v <= 8; v++) begin
            access(1'b0, 16'((v << 12) | 16'hFFF), 3'd4, 16'(16'hC070 + v), 1, 1'b0, 1'b0);
        end

`ifdef TLBCTL_FLUSH_EN
        // Flush in IDLE alongside a hit: lookup uses pre-flush contents
        access(1'b0, 16'h8ABC, 3'd0, 16'hC011, 1, 1'b1, 1'b0);
        m0 = mr_cnt;
        access(1'b0, 16'h8ABC, 3'd0, 16'hC012, 1, 1'b0, 1'b0);
        check("flush_idle_invalidates", 32'(mr_cnt != m0), 32'd1);
        access(1'b0, 16'h5000, 3'd0, 16'hC015, 1, 1'b0, 1'b0);
        // Flush during WALK: filled entry survives, others are gone
        access(1'b0, 16'h6000, 3'd0, 16'hC016, 3, 1'b0, 1'b1);
        m0 = mr_cnt;
        access(1'b0, 16'h6123, 3'd0, 16'h0000, 1, 1'b0, 1'b0);
        check("flush_walk_fill_survives", 32'(mr_cnt - m0), 32'd0);
        m0 = mr_cnt;
        access(1'b0, 16'h5123, 3'd0, 16'hC025, 1, 1'b0, 1'b0);
        check("flush_walk_others_miss", 32'(mr_cnt != m0), 32'd1);
`endif

        tick();
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_miss_controller.md
# tlb_miss_controller

Sequencing controller for the data-side TLB lookup stage. Holds a small fully-associative DTLB and translates each load/store virtual address. On a miss it stalls the stage by dropping `enable_tlblookup`, walks the single-level page table through a req/ack memory port, fills the TLB and replays. Invalid and write-protect violations are reported to the ROB as exceptions tagged with the instruction's ROB index.

## Interface
Parameters:
- `TLB_ENTRIES`, 4: number of DTLB entries; a power of two, 2 to 8.
- `PPN_W`, 8: physical page number width. Physical address is `PPN_W + 12` bits.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: stage holds a load or store (`ldSt_enable != 0`).
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_vaddr` in 16: virtual address (ALU result).
- `req_rob` in 3: ROB tail index of the request.
- `ptbr` in 16: page-table base byte address.
- `enable_tlblookup` out 1: stage register enable; 0 = stall.
- `xlat_valid` out 1: translation valid in this cycle.
- `xlat_paddr` out `PPN_W+12`: physical address.
- `mem_req` out 1: page-table read request.
- `mem_addr` out 16: PTE byte address.
- `mem_ack` in 1: read done; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 16: PTE.
- `exc_valid` out 1: one-cycle exception pulse.
- `exc_rob` out 3: ROB index of the faulting request.
- `exc_cause` out 2: 01 = invalid page, 10 = write-protect.
- `tlb_flush` in 1: invalidate all entries. Present only with `TLBCTL_FLUSH_EN`.

## Operation
- Virtual address split: VPN = `req_vaddr[15:12]`, offset = `req_vaddr[11:0]`.
- PTE format: bit 15 = V, bit 14 = W, bits `PPN_W-1:0` = PPN. All other bits are ignored.
- A TLB entry holds: valid, VPN, W, PPN.

State machine:
- **IDLE**
  - `req_valid` with a hit and no violation: `xlat_valid=1`, `xlat_paddr={PPN, offset}`, `enable_tlblookup=1`.
  - Hit, store, W=0: go to FAULT with cause 10. `enable_tlblookup=0` in this cycle.
  - Miss: latch VPN, `req_is_store` and `req_rob`; set `enable_tlblookup=0`; go to WALK.
- **WALK**
  - `mem_req=1` and `mem_addr = ptbr + {11'b0, VPN, 1'b0}`, wrapping modulo 2^16.
  - `mem_req` stays high until the `mem_ack` cycle; `mem_addr` is stable throughout.
  - On `mem_ack`, latch `mem_rdata`.
  - If V=0, or latched store with W=0: go to FAULT (cause 01 takes priority over 10).
  - Otherwise go to FILL.
- **FILL**
  - Write the entry.
  - Victim is the lowest-index invalid entry. If every entry is valid, the victim is the round-robin pointer, which then increments and wraps.
  - Go to IDLE. The replay hits in that next IDLE cycle.
- **FAULT**
  - `exc_valid=1` for exactly one cycle, with `exc_rob` and `exc_cause` set.
  - `enable_tlblookup=1` so the stage drains the faulting instruction.
  - Go to IDLE. Nothing is filled.
- `enable_tlblookup=0` in every WALK and FILL cycle, and in the IDLE cycle that detects a miss or violation.
- `req_*` inputs are ignored outside IDLE. The stage is stalled and holds them.
- `mem_ack` is ignored outside WALK.

## Timing
- Hit latency: 0 cycles. Translation is combinational in the request cycle.
- Miss penalty, with ack arriving N cycles after `mem_req` rises (N ≥ 1): 1 (detect) + N (WALK) + 1 (FILL) cycles, then translation on the replay cycle.
- Values while `reset=0`, applied immediately and asynchronously:
  - state = IDLE; all entries invalid; round-robin pointer = 0.
  - `mem_req=0`, `mem_addr=0`, `exc_valid=0`, `exc_rob=0`, `exc_cause=0`, `xlat_valid=0`, `xlat_paddr=0`, `enable_tlblookup=1`.
- Reset asserted during WALK drops `mem_req` at once. The memory side discards the outstanding request.
- `mem_ack` arriving in the same cycle `mem_req` rises is legal, giving a 1-cycle walk.

## Configuration
- `TLBCTL_FLUSH_EN` defined:
  - `tlb_flush` port exists.
  - Flush in IDLE: every entry is invalidated at the next edge and the pointer resets to 0. A lookup in that same cycle still uses the pre-flush contents.
  - Flush in WALK, FILL or FAULT: latched as pending. The pending flush is applied at the FILL or FAULT exit edge, before the FILL write, so the newly filled entry survives.
- Undefined: no port and no pending flag. Entries are invalidated only by reset.

## Structure
- Package `tlbctl_pkg`:
  - state enum (IDLE, WALK, FILL, FAULT);
  - PTE bit positions (V=15, W=14);
  - cause codes `CAUSE_INVALID=2'b01` and `CAUSE_WPROT=2'b10`;
  - `PAGE_OFFSET_W=12`.
- Sub-module `tlb_array`:
  - entry storage, parallel VPN compare giving hit, hit index, W and PPN;
  - victim selection and the round-robin pointer;
  - write port and flush.
- The controller FSM stays in the top module.

## Test plan
- Cold miss: load, vaddr 16'h3ABC, ptbr 16'h1000.
  - Required: `mem_addr=16'h1006`.
  - Ack after 3 cycles with `mem_rdata=16'hC025`.
  - Required: FILL, then the replay gives `xlat_paddr=20'h25ABC`.
  - `enable_tlblookup` is low for exactly 5 cycles.
- Hit after fill: load 16'h3000 gives `xlat_paddr=20'h25000` with no stall and `mem_req` staying 0.
- Invalid PTE: walk returns 16'h0012 for a store with `req_rob=5`.
  - Required: one-cycle `exc_valid`, `exc_rob=5`, `exc_cause=01`.
  - No fill; the same vaddr misses again afterwards.
- Write-protect on hit: entry with W=0, then a store to it.
  - Required: FAULT with cause 10 and no `mem_req`.
- Replacement: fill VPNs 0 through 4 with `TLB_ENTRIES=4`.
  - Required: VPN 4 evicts VPN 0 and the pointer becomes 1.
  - A following lookup of VPN 0 misses.
- Reset mid-walk: assert `reset=0` while in WALK.
  - Required: `mem_req` falls in the same cycle, all entries become invalid, and the controller restarts in IDLE.
  - With `TLBCTL_FLUSH_EN`: a flush issued during WALK, then the walk completes; the filled entry hits and all other entries miss.
